// File: rtl/dequant_zigzag.sv
// dequant_zigzag: serial zigzag coefficients -> dequantized, saturated 8x8 row-major block
// Publishes each completed block in parallel with a one-cycle valid_out pulse and its channel tag.
module dequant_zigzag #(
    parameter int COEF_W = 11,
    parameter int Q_W    = 8,
    parameter int OUT_W  = 12
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  coef_valid,
    output logic                                  coef_ready,
    input  logic signed [COEF_W-1:0]              coef_in,
    input  logic                                  coef_last,
    input  logic [1:0]                            coef_channel,
    input  logic                                  qt_wr_en,
    input  logic                                  qt_wr_sel,
    input  logic [5:0]                            qt_wr_addr,
    input  logic [Q_W-1:0]                        qt_wr_data,
    output logic signed [7:0][7:0][OUT_W-1:0]     idct_in,
    output logic                                  valid_out,
    output logic [1:0]                            channel_out
);
    typedef enum logic {FILL, ZERO} state_t;
    localparam int PW = COEF_W + Q_W + 1;
    localparam logic signed [PW-1:0] MAXV = PW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = -MAXV - 1;
    // zigzag index -> row*8+col
    localparam logic [5:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    state_t                   state;
    logic [5:0]               k;
    logic [1:0]               ch_r;
    logic [Q_W-1:0]           qt [2][64];
    logic [63:0][OUT_W-1:0]   work, work_nx;
    logic [1:0]               cur_ch;
    logic [Q_W-1:0]           q;
    logic signed [PW-1:0]     prod;
    logic [OUT_W-1:0]         sat;
    logic                     xfer, wr, done;

    assign coef_ready = state == FILL && !rst;
    assign xfer       = coef_valid && coef_ready;
    assign wr         = state == ZERO || xfer;
    assign done       = wr && k == 6'd63;
    assign cur_ch     = (state == FILL && k == 6'd0) ? coef_channel : ch_r;
    assign q          = qt[cur_ch != 2'd0][k];
    assign prod       = PW'(coef_in) * PW'(signed'({1'b0, q}));
    assign sat        = prod > MAXV ? MAXV[OUT_W-1:0] : prod < MINV ? MINV[OUT_W-1:0] : prod[OUT_W-1:0];

    always_comb begin
        work_nx = work;
        if (wr) work_nx[ZZ[k]] = state == ZERO ? '0 : sat;
    end

    // every position is rewritten each block, so the buffer needs no reset
    always_ff @(posedge clk) work <= work_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            k           <= '0;
            ch_r        <= '0;
            valid_out   <= 1'b0;
            idct_in     <= '0;
            channel_out <= '0;
            for (int i = 0; i < 64; i++) begin
                qt[0][i] <= Q_W'(1);
                qt[1][i] <= Q_W'(1);
            end
        end else begin
            valid_out <= done;
            if (qt_wr_en) qt[qt_wr_sel][qt_wr_addr] <= qt_wr_data;
            if (xfer && k == 6'd0) ch_r <= coef_channel;
            if (done) begin
                idct_in     <= work_nx;
                channel_out <= ch_r;
                k           <= '0;
                state       <= FILL;
            end else if (wr) begin
                k <= k + 6'd1;
                if (state == FILL && coef_last) state <= ZERO;
            end
        end
    end
endmodule
